// File: rtl/ntt_butterfly_pkg.sv
// Shared NTT definitions: field constants for the Fermat prime 2^M+1,
// butterfly mode encoding and single-correction modular add/subtract.
package ntt_butterfly_pkg;

    localparam int M  = 16;
    localparam int DW = M + 1;
    localparam int PW = 2 * M + 1;

    localparam logic [DW-1:0] PRIME = {1'b1, {(M-1){1'b0}}, 1'b1};

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } mode_e;

    // Both operands must already lie in [0, PRIME-1], so one correction suffices.
    function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME}) begin
            s = s - {1'b0, PRIME};
        end
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sub_mod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) begin
            d = d + {1'b0, PRIME};
        end
        return d[DW-1:0];
    endfunction

endpackage

// File: rtl/ntt_butterfly_reduce.sv
// Combinational reduction of a full (2M+1)-bit product modulo 2^M+1,
// folding the upper half back in with 2^M == -1.
module fermat_reduce
    import ntt_butterfly_pkg::*;
(
    input  logic [PW-1:0] prod,
    output logic [DW-1:0] res
);

    localparam int RW = M + 3;

    logic signed [RW-1:0] lo_s;
    logic signed [RW-1:0] hi_s;
    logic signed [RW-1:0] prime_s;
    logic signed [RW-1:0] r;

    // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
    always_comb begin
        lo_s    = signed'({3'b000, prod[M-1:0]});
        hi_s    = signed'({2'b00, prod[PW-1:M]});
        prime_s = signed'({2'b00, PRIME});
        r       = lo_s - hi_s;
        // r spans [-2^M, 2^M-1]; one correction in either direction lands in [0, p-1].
        if (r < 0) begin
            r = r + prime_s;
        end else if (r >= prime_s) begin
            r = r - prime_s;
        end
        res = r[DW-1:0];
    end

endmodule

// File: rtl/ntt_butterfly.sv
// Three-stage radix-2 NTT butterfly (Cooley-Tukey or Gentleman-Sande) over
// 2^M+1 with valid/ready flow control and a pass-through sideband tag.
module ntt_butterfly
    import ntt_butterfly_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    input  logic [DW-1:0]    in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_x,
    output logic [DW-1:0]    out_y,
    output logic [TAG_W-1:0] out_tag
);

    logic en;

    logic             s1_valid_q, s1_valid_d;
    mode_e            s1_mode_q,  s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic [PW-1:0]    s1_prod_q,  s1_prod_d;
    logic [DW-1:0]    s1_op_q,    s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    mode_e            s2_mode_q,  s2_mode_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
    logic [DW-1:0]    s2_t_q,     s2_t_d;
    logic [DW-1:0]    s2_op_q,    s2_op_d;

    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_x_q,     out_x_d;
    logic [DW-1:0]    out_y_q,     out_y_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    mode_e         mode_in;
    logic [DW-1:0] mul_a;
    logic [PW-1:0] mul_p;
    logic [DW-1:0] red_t;

    // The whole pipe advances together; a full, stalled output freezes every stage.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign mode_in  = mode_e'(in_mode);

    // Stage 1: GS pre-add/subtract and the modular multiply operand select.
    always_comb begin
        mul_a = (mode_in == MODE_GS) ? sub_mod(in_a, in_b) : in_b;
        // Zero-extending to PW bits is exact: the largest product is 2^(2M).
        mul_p = {{M{1'b0}}, mul_a} * {{M{1'b0}}, in_w};

        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_tag_d   = s1_tag_q;
        s1_prod_d  = s1_prod_q;
        s1_op_d    = s1_op_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_mode_d  = mode_in;
            s1_tag_d   = in_tag;
            s1_prod_d  = mul_p;
            s1_op_d    = (mode_in == MODE_GS) ? add_mod(in_a, in_b) : in_a;
        end
    end

    fermat_reduce u_reduce (
        .prod (s1_prod_q),
        .res  (red_t)
    );

    // Stage 2: capture the reduced product alongside the carried operand.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        s2_tag_d   = s2_tag_q;
        s2_t_d     = s2_t_q;
        s2_op_d    = s2_op_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_mode_d  = s1_mode_q;
            s2_tag_d   = s1_tag_q;
            s2_t_d     = red_t;
            s2_op_d    = s1_op_q;
        end
    end

    // Stage 3: CT post-add/subtract; GS results are already complete.
    always_comb begin
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_tag_d   = out_tag_q;
        if (en) begin
            out_valid_d = s2_valid_q;
            out_tag_d   = s2_tag_q;
            if (s2_mode_q == MODE_CT) begin
                out_x_d = add_mod(s2_op_q, s2_t_q);
                out_y_d = sub_mod(s2_op_q, s2_t_q);
            end else begin
                out_x_d = s2_op_q;
                out_y_d = s2_t_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are cleared too, not just valids, so visible outputs read 0 in reset.
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= MODE_CT;
            s1_tag_q    <= '0;
            s1_prod_q   <= '0;
            s1_op_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= MODE_CT;
            s2_tag_q    <= '0;
            s2_t_q      <= '0;
            s2_op_q     <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_tag_q    <= s1_tag_d;
            s1_prod_q   <= s1_prod_d;
            s1_op_q     <= s1_op_d;
            s2_valid_q  <= s2_valid_d;
            s2_mode_q   <= s2_mode_d;
            s2_tag_q    <= s2_tag_d;
            s2_t_q      <= s2_t_d;
            s2_op_q     <= s2_op_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Directed and scoreboarded bench for ntt_butterfly: hand-computed vectors,
// a back-to-back burst, an output stall and a mid-stream reset.
module tb_ntt_butterfly;

    localparam int     DW    = 17;
    localparam int     TAG_W = 8;
    localparam longint P     = 65537;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [DW-1:0]    in_a, in_b, in_w;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_x, out_y;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    ntt_butterfly #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_tag   (out_tag)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int n_out    = 0;
    bit lat_chk  = 1'b0;

    typedef struct {
        longint x;
        longint y;
        longint tag;
        int     cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic mode, input longint a, input longint b,
                                   input longint w, input longint tag, input int c);
        exp_t e;
        longint t;
        if (!mode) begin
            t   = (b * w) % P;
            e.x = (a + t) % P;
            e.y = (a - t + P) % P;
        end else begin
            e.x = (a + b) % P;
            e.y = (((a - b + P) % P) * w) % P;
        end
        e.tag = tag;
        e.cyc = c;
        return e;
    endfunction

    // Scoreboard: expectations are formed from accepted operands, checked in order at the output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_x",   64'(out_x),   64'(mon_e.x));
                    check("sb_y",   64'(out_y),   64'(mon_e.y));
                    check("sb_tag", 64'(out_tag), 64'(mon_e.tag));
                    if (lat_chk) check("sb_latency", 64'(cyc - mon_e.cyc), 64'd3);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_mode, longint'(in_a), longint'(in_b), longint'(in_w),
                                   longint'(in_tag), cyc));
            end
        end
    end

    // Presents one operand set and returns 1ns after the edge that accepted it.
    task automatic send(input logic mode, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] w, input logic [TAG_W-1:0] tag);
        int t;
        in_mode  = mode;
        in_a     = a;
        in_b     = b;
        in_w     = w;
        in_tag   = tag;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic mode, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] w,
                            input logic [TAG_W-1:0] tag, input logic [DW-1:0] ex,
                            input logic [DW-1:0] ey);
        send(mode, a, b, w, tag);
        check({name, "_v_e0"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({name, "_v_e1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({name, "_v_e2"}, 64'(out_valid), 64'd1);
        check({name, "_x"},    64'(out_x),     64'(ex));
        check({name, "_y"},    64'(out_y),     64'(ey));
        check({name, "_tag"},  64'(out_tag),   64'(tag));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (errors=%0d)", n_errs);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [DW-1:0] sx, sy;
        logic [TAG_W-1:0] st;
        bit have;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_w      = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_x",     64'(out_x),     64'd0);
        check("rst_y",     64'(out_y),     64'd0);
        check("rst_tag",   64'(out_tag),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed vectors, including the 2^32 product and GS wrap-around.
        directed("ct_small",  1'b0, 17'd5,     17'd3,     17'd2,     8'hA5, 17'd11, 17'd65536);
        directed("ct_2pow32", 1'b0, 17'd0,     17'd65536, 17'd65536, 8'h3C, 17'd1,  17'd65536);
        directed("gs_small",  1'b1, 17'd10,    17'd20,    17'd3,     8'h11, 17'd30, 17'd65507);
        directed("gs_wrap",   1'b1, 17'd65536, 17'd1,     17'd5,     8'h22, 17'd0,  17'd65527);
        @(posedge clk); #1;

        // Back-to-back burst: every result 3 cycles after acceptance, in order.
        lat_chk = 1'b1;
        base    = n_out;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) send(1'b0, 17'd65536, 17'd65536, 17'd65536, 8'(i));
            else if (i == 1) send(1'b1, 17'd65536, 17'd65536, 17'd65536, 8'(i));
            else send(1'($urandom_range(0, 1)), 17'($urandom_range(0, 65536)),
                      17'($urandom_range(0, 65536)), 17'($urandom_range(0, 65536)), 8'(i));
        end
        repeat (6) @(posedge clk);
        #1;
        lat_chk = 1'b0;
        check("burst_count", 64'(n_out - base), 64'd16);

        // Output stall of 6 cycles with 4 operand sets offered.
        base = n_out;
        have = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(i[0], 17'(1000 * i + 7), 17'(65536 - i), 17'(3 + i), 8'(8'h80 + i));
                end
            end
            begin
                out_ready = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid) begin
                        check("stall_in_ready", 64'(in_ready), 64'd0);
                        if (!have) begin
                            sx = out_x; sy = out_y; st = out_tag; have = 1'b1;
                        end else begin
                            check("stall_x_hold",   64'(out_x),   64'(sx));
                            check("stall_y_hold",   64'(out_y),   64'(sy));
                            check("stall_tag_hold", 64'(out_tag), 64'(st));
                        end
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("stall_count",   64'(n_out - base), 64'd4);
        check("stall_drained", 64'(sb.size()),    64'd0);

        // Reset with a full pipe: nothing stale may emerge afterwards.
        send(1'b0, 17'd100, 17'd200, 17'd300, 8'h51);
        send(1'b1, 17'd400, 17'd500, 17'd600, 8'h52);
        send(1'b0, 17'd700, 17'd800, 17'd900, 8'h53);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_x",     64'(out_x),     64'd0);
        check("mid_rst_y",     64'(out_y),     64'd0);
        check("mid_rst_tag",   64'(out_tag),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        directed("post_rst", 1'b0, 17'd5, 17'd3, 17'd2, 8'h77, 17'd11, 17'd65536);
        repeat (3) @(posedge clk);
        #1;
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
